pipe_stage_buf: RTL

//  Parametrised, elastic inter-stage pipeline buffer (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries a data bundle and a control bundle per entry, using a valid/ready handshake.
//  - A 2-entry skid lets a downstream stall back-pressure upstream with no bubble and no loss.
//  - A flush input squashes the stage: after a flush, out_ctrl presents the NOP control word.

---
 rtl/pipe_stage_buf.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic 2-entry inter-stage pipeline buffer with flush
// Head register drives the outputs; a skid register absorbs one entry during a downstream stall.
module pipe_stage_buf #(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 14,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        next_state;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              load_head_in;
  logic              load_head_skid;
  logic              load_skid;
  logic              it;
  logic              ot;

  assign it = in_valid && in_ready;
  assign ot = out_valid && out_ready;

  // State register and all registered outputs; the pipeline advances on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      occupancy <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_ctrl  <= CTRL_NOP;
      out_data  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      occupancy <= next_state;
      out_valid <= (next_state != EMPTY);
      in_ready  <= (next_state != TWO);
      if (next_state == EMPTY) begin
        out_ctrl <= CTRL_NOP;
      end else if (load_head_in) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end else if (load_head_skid) begin
        out_data <= skid_data;
        out_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  always_comb begin
    next_state = occupancy;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (occupancy)
        EMPTY:   if (it) next_state = ONE;
        ONE: begin
          if (it && !ot)      next_state = TWO;
          else if (ot && !it) next_state = EMPTY;
        end
        TWO:     if (ot) next_state = ONE;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Datapath load strobes; a flush suppresses every load so the squashed entry never lands.
  always_comb begin
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      case (occupancy)
        EMPTY: load_head_in = it;
        ONE: begin
          load_head_in = it && ot;
          load_skid    = it && !ot;
        end
        TWO:     load_head_skid = ot;
        default: ;
      endcase
    end
  end

endmodule
